mc_control_unit: RTL and testbench

Parametrised multicycle control unit for the MIPS-style core; successor to the fixed-latency FSM that drives the shared instruction/data memory datapath. It sequences fetch, decode, execute, memory and writeback states and drives every datapath mux select and register enable. It adds a memory ready handshake for variable-latency memory, bne/j/shift support, branch resolution into a single PC enable, a sticky illegal-opcode trap, and optional performance counters.

---
 rtl/mc_ctrl_pkg.sv | 97 +++++++++
 rtl/mc_perf_cnt.sv | 29 ++
 rtl/mc_control_unit.sv | 113 +++++++++++
 tb/tb_mc_control_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encoding, opcode/funct
// constants, mux-select encodings and the per-state control word.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
      S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_ILLEGAL
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_A     = 2'b01;
   localparam logic [1:0] SRCA_SHAMT = 2'b10;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_SIMM = 2'b10;
   localparam logic [1:0] SRCB_ZIMM = 2'b11;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OR    = 2'b11;

   localparam logic [1:0] PC_ALURES = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // Gate bits (fetch_gate, br_en, retire_on_ready) mark outputs finished by live inputs.
   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       memto_reg;
      logic       fetch_gate;
      logic       br_en;
      logic       br_ne;
      logic       jump;
      logic       retire;
      logic       retire_on_ready;
      logic       illegal;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
   } ctrl_t;

   function automatic ctrl_t state_ctrl(input state_t s, input logic shift,
                                        input logic ori, input logic bne);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:  begin c.mem_req = 1'b1; c.alu_src_b = SRCB_ONE; c.fetch_gate = 1'b1; end
         S_DECODE: c.alu_src_b = SRCB_SIMM;
         S_MEMADR: begin c.alu_src_a = SRCA_A; c.alu_src_b = SRCB_SIMM; end
         S_MEMRD:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
         S_MEMWB:  begin c.reg_write = 1'b1; c.memto_reg = 1'b1; c.retire = 1'b1; end
         S_MEMWR:  begin
            c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = 1'b1; c.retire_on_ready = 1'b1;
         end
         S_EXEC:   begin
            c.alu_op    = ALU_FUNCT;
            c.alu_src_a = shift ? SRCA_SHAMT : SRCA_A;
            c.alu_src_b = SRCB_B;
         end
         S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.retire = 1'b1; end
         S_IEXEC:  begin
            c.alu_src_a = SRCA_A;
            c.alu_src_b = ori ? SRCB_ZIMM : SRCB_SIMM;
            c.alu_op    = ori ? ALU_OR : ALU_ADD;
         end
         S_IWB:    begin c.reg_write = 1'b1; c.retire = 1'b1; end
         S_BRANCH: begin
            c.alu_src_a = SRCA_A; c.alu_op = ALU_SUB; c.pc_src = PC_ALUOUT;
            c.br_en = 1'b1; c.br_ne = bne; c.retire = 1'b1;
         end
         S_JUMP:    begin c.pc_src = PC_JUMP; c.jump = 1'b1; c.retire = 1'b1; end
         S_ILLEGAL: c.illegal = 1'b1;
         default:   c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// Pair of free-running wrap-around event counters: index 0 counts cycles, index 1 retires.
module mc_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cycle_en,
   input  logic             instr_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   logic [1:0] cnt_en;
   assign cnt_en = {instr_en, cycle_en};

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
         if (rst)
            cnt_reg <= '0;
         else if (cnt_en[gi])
            cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign cycle_cnt = g_cnt[0].cnt_reg;
   assign instr_cnt = g_cnt[1].cnt_reg;

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM with memory-ready handshake and sticky illegal trap.
// Define MC_CTRL_PERF_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int OPW   = 6,
   parameter int FNW   = 6,
   parameter int CNT_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic [FNW-1:0] func,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           mem_req,
   output logic           IorD,
   output logic           IRWrite,
   output logic           MemWrite,
   output logic           RegWrite,
   output logic           RegDst,
   output logic           MemtoReg,
   output logic [1:0]     ALUSrcA,
   output logic [1:0]     ALUSrcB,
   output logic [1:0]     ALUOp,
   output logic [1:0]     PCSrc,
   output logic           pc_en,
   output logic           illegal,
   output logic           retire
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   state_t state_reg, state_next;
   ctrl_t  ctrl_reg;

   logic is_rtype, is_lw, is_sw, is_beq, is_bne, is_addi, is_ori, is_j, is_shift;
   assign is_rtype = (opcode == OPW'(OP_RTYPE));
   assign is_lw    = (opcode == OPW'(OP_LW));
   assign is_sw    = (opcode == OPW'(OP_SW));
   assign is_beq   = (opcode == OPW'(OP_BEQ));
   assign is_bne   = (opcode == OPW'(OP_BNE));
   assign is_addi  = (opcode == OPW'(OP_ADDI));
   assign is_ori   = (opcode == OPW'(OP_ORI));
   assign is_j     = (opcode == OPW'(OP_J));
   assign is_shift = (func == FNW'(FN_SLL)) || (func == FNW'(FN_SRL));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FETCH:  if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            if (is_rtype)                state_next = S_EXEC;
            else if (is_addi || is_ori)  state_next = S_IEXEC;
            else if (is_lw || is_sw)     state_next = S_MEMADR;
            else if (is_beq || is_bne)   state_next = S_BRANCH;
            else if (is_j)               state_next = S_JUMP;
            else                         state_next = S_ILLEGAL;
         end
         S_MEMADR:  state_next = is_lw ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (mem_ready) state_next = S_MEMWB;
         S_MEMWR:   if (mem_ready) state_next = S_FETCH;
         S_EXEC:    state_next = S_ALUWB;
         S_IEXEC:   state_next = S_IWB;
         S_ILLEGAL: state_next = S_ILLEGAL;
         default:   state_next = S_FETCH;
      endcase
   end

   // The control word is computed for the state being entered, so every Moore
   // output comes straight from a flop; opcode/func are stable once IR is loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_FETCH;
         ctrl_reg  <= state_ctrl(S_FETCH, 1'b0, 1'b0, 1'b0);
      end else begin
         state_reg <= state_next;
         ctrl_reg  <= state_ctrl(state_next, is_shift, is_ori, is_bne);
      end
   end

   assign mem_req  = ctrl_reg.mem_req;
   assign IorD     = ctrl_reg.iord;
   assign MemWrite = ctrl_reg.mem_write;
   assign RegWrite = ctrl_reg.reg_write;
   assign RegDst   = ctrl_reg.reg_dst;
   assign MemtoReg = ctrl_reg.memto_reg;
   assign ALUSrcA  = ctrl_reg.alu_src_a;
   assign ALUSrcB  = ctrl_reg.alu_src_b;
   assign ALUOp    = ctrl_reg.alu_op;
   assign PCSrc    = ctrl_reg.pc_src;
   assign illegal  = ctrl_reg.illegal;
   assign IRWrite  = ctrl_reg.fetch_gate & mem_ready;
   assign pc_en    = (ctrl_reg.fetch_gate & mem_ready)
                   | (ctrl_reg.br_en & (zero ^ ctrl_reg.br_ne))
                   | ctrl_reg.jump;
   assign retire   = ctrl_reg.retire | (ctrl_reg.retire_on_ready & mem_ready);

`ifdef MC_CTRL_PERF_EN
   mc_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
      .clk       (clk),
      .rst       (rst),
      .cycle_en  (state_reg != S_ILLEGAL),
      .instr_en  (retire),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
   );
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: per-cycle expected control vectors derived
// from each instruction's phase sequence, with random memory waits and ignored inputs.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] func = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg;
   logic [1:0] ALUSrcA, ALUSrcB, ALUOp, PCSrc;
   logic       pc_en, illegal, retire;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   int n_chk = 0;
   int n_fail = 0;
   int exp_cyc = 0;
   int exp_ret = 0;

   logic [17:0] eq_q[$];
   bit          rq_q[$];
   bit          zq_q[$];
   bit          cq_q[$];

   always #5 clk = ~clk;

   mc_control_unit #(.OPW(6), .FNW(6), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
      .pc_en(pc_en), .illegal(illegal), .retire(retire)
`ifdef MC_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   wire [17:0] obs = {mem_req, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
                      ALUSrcA, ALUSrcB, ALUOp, PCSrc, pc_en, illegal, retire};

   function automatic logic [17:0] v(input bit mreq, iord, irw, mw, rw, rd, m2r,
                                     input logic [1:0] a, b, op, pcs,
                                     input bit pce, ill, ret);
      return {mreq, iord, irw, mw, rw, rd, m2r, a, b, op, pcs, pce, ill, ret};
   endfunction

   localparam logic [17:0] FETCH_WAIT = {7'b1000000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000};
   localparam logic [17:0] FETCH_RDY  = {7'b1010000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b100};
   localparam logic [17:0] DECODE_V   = {7'b0000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000};
   localparam logic [17:0] ILLEGAL_V  = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010};

   task automatic check_vec(input string tag, input logic [17:0] e);
      n_chk++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, e);
      end
   endtask

   task automatic check_cnt(input string tag);
`ifdef MC_CTRL_PERF_EN
      n_chk++;
      assert (cycle_cnt === 32'(exp_cyc)) else begin
         n_fail++;
         $error("FAIL %s cycle_cnt observed=%0d expected=%0d", tag, cycle_cnt, exp_cyc);
      end
      n_chk++;
      assert (instr_cnt === 32'(exp_ret)) else begin
         n_fail++;
         $error("FAIL %s instr_cnt observed=%0d expected=%0d", tag, instr_cnt, exp_ret);
      end
`else
      $display("%s: counters not built", tag);
`endif
   endtask

   task automatic push(input logic [17:0] e, input bit r, input bit z, input bit c);
      eq_q.push_back(e); rq_q.push_back(r); zq_q.push_back(z); cq_q.push_back(c);
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic do_reset(input string tag);
      rst = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_cyc = 0;
      exp_ret = 0;
      #1;
      check_vec({tag, " outputs"}, FETCH_WAIT);
      check_cnt(tag);
      $display("reset %s: outputs=%b", tag, obs);
   endtask

   // Expands one instruction into its expected per-cycle outputs, then drives and checks.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                            input int fw, input int mw, input int abort_at,
                            input string tag);
      bit retires = 1'b1;
      bit taken;
      eq_q.delete(); rq_q.delete(); zq_q.delete(); cq_q.delete();
      for (int i = 0; i < fw; i++) push(FETCH_WAIT, 1'b0, rb(), 1'b1);
      push(FETCH_RDY, 1'b1, rb(), 1'b1);
      push(DECODE_V, rb(), rb(), 1'b1);
      case (op)
         6'b100011: begin
            push(v(0,0,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0,0), rb(), rb(), 1'b1);
            for (int i = 0; i < mw; i++)
               push(v(1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0), 1'b0, rb(), 1'b1);
            push(v(1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0), 1'b1, rb(), 1'b1);
            push(v(0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,1), rb(), rb(), 1'b1);
         end
         6'b101011: begin
            push(v(0,0,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0,0), rb(), rb(), 1'b1);
            for (int i = 0; i < mw; i++)
               push(v(1,1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0), 1'b0, rb(), 1'b1);
            push(v(1,1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,1), 1'b1, rb(), 1'b1);
         end
         6'b000000: begin
            push(v(0,0,0,0,0,0,0, (fn == 6'd0 || fn == 6'd2) ? 2'b10 : 2'b01,
                   2'b00,2'b10,2'b00, 0,0,0), rb(), rb(), 1'b1);
            push(v(0,0,0,0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,1), rb(), rb(), 1'b1);
         end
         6'b001000, 6'b001101: begin
            if (op == 6'b001000)
               push(v(0,0,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0,0), rb(), rb(), 1'b1);
            else
               push(v(0,0,0,0,0,0,0, 2'b01,2'b11,2'b11,2'b00, 0,0,0), rb(), rb(), 1'b1);
            push(v(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,1), rb(), rb(), 1'b1);
         end
         6'b000100, 6'b000101: begin
            taken = (op == 6'b000100) ? z : !z;
            push(v(0,0,0,0,0,0,0, 2'b01,2'b00,2'b01,2'b01, taken,0,1), rb(), z, 1'b1);
         end
         6'b000010:
            push(v(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b10, 1,0,1), rb(), rb(), 1'b1);
         default: begin
            retires = 1'b0;
            for (int i = 0; i < 4; i++) push(ILLEGAL_V, rb(), rb(), 1'b0);
         end
      endcase

      opcode = op;
      func   = fn;
      foreach (eq_q[i]) begin
         if (abort_at >= 0 && i == abort_at) break;
         mem_ready = rq_q[i];
         zero      = zq_q[i];
         #1;
         check_vec($sformatf("%s c%0d", tag, i), eq_q[i]);
         @(posedge clk); #1;
         if (cq_q[i]) exp_cyc++;
      end
      if (retires && abort_at < 0) exp_ret++;
      check_cnt(tag);
      $display("instr %s op=%b fn=%b z=%0d fw=%0d mw=%0d cycles=%0d", tag, op, fn, z,
               fw, mw, (abort_at >= 0) ? abort_at : eq_q.size());
   endtask

   logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b000101, 6'b001000, 6'b001101, 6'b000010};
   logic [5:0] fns [5] = '{6'b000000, 6'b000010, 6'b100000, 6'b100101, 6'b101010};

   initial begin
      do_reset("initial");
      run_instr(6'b100011, 6'd0, 1'b0, 0, 0, -1, "lw_ready");
      run_instr(6'b101011, 6'd0, 1'b0, 0, 3, -1, "sw_wait3");
      run_instr(6'b000100, 6'd0, 1'b1, 0, 0, -1, "beq_z1");
      run_instr(6'b000101, 6'd0, 1'b1, 0, 0, -1, "bne_z1");
      run_instr(6'b000100, 6'd0, 1'b0, 0, 0, -1, "beq_z0");
      run_instr(6'b000101, 6'd0, 1'b0, 0, 0, -1, "bne_z0");
      run_instr(6'b000000, 6'b000000, 1'b0, 0, 0, -1, "r_sll");
      run_instr(6'b000000, 6'b000010, 1'b0, 0, 0, -1, "r_srl");
      run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, -1, "r_add");
      run_instr(6'b000010, 6'd0, 1'b0, 0, 0, -1, "j");
      run_instr(6'b001000, 6'd0, 1'b0, 0, 0, -1, "addi");
      run_instr(6'b001101, 6'd0, 1'b0, 0, 0, -1, "ori");
      run_instr(6'b100011, 6'd0, 1'b0, 2, 2, -1, "lw_waits");

      for (int k = 0; k < 40; k++) begin
         run_instr(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 4)], rb(),
                   $urandom_range(0, 3), $urandom_range(0, 3), -1, $sformatf("rnd%0d", k));
      end

      run_instr(6'b111111, 6'd0, 1'b0, 1, 0, -1, "illegal");
      do_reset("after_illegal");
      run_instr(6'b000010, 6'd0, 1'b0, 0, 0, -1, "j_after_illegal");

      run_instr(6'b101011, 6'd0, 1'b0, 0, 5, 5, "sw_abort");
      do_reset("rst_in_memwr");
      run_instr(6'b100011, 6'd0, 1'b0, 1, 1, -1, "lw_after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
